// File: rtl/backpressure_credit_machine.sv
// Credit-based flow controller for a fixed-latency, free-running arithmetic stage.
// Optional stall counter output is enabled with `define BACKPRESSURE_STALL_CNT_EN.
module backpressure_credit_machine #(
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RES_WIDTH  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                snk_valid,
    input  logic [DATA_WIDTH-1:0]               snk_data,
    output logic                                snk_ready,
    output logic                                issue_valid,
    input  logic [RES_WIDTH-1:0]                res_data,
    output logic                                src_valid,
    output logic [RES_WIDTH+DATA_WIDTH-1:0]     src_data,
    input  logic                                src_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
`ifdef BACKPRESSURE_STALL_CNT_EN
    ,
    output logic [31:0]                         stall_cnt
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = RES_WIDTH + DATA_WIDTH;
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [LW-1:0]         occ_r;
    logic [LW-1:0]         level_r;
    logic [LATENCY-1:0]    valid_d_r;
    logic [DATA_WIDTH-1:0] data_d_r [LATENCY];
    logic [EW-1:0]         mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic                  accept_s;
    logic                  pop_s;
    logic                  wr_s;

    // Pointer wrap is explicit so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        ptr_next = (p == PTR_LAST) ? PW'(0) : p + PW'(1);
    endfunction

    // A pop frees a credit in the same cycle, so a full machine can still accept.
    assign src_valid   = (level_r != LW'(0));
    assign pop_s       = src_valid & src_ready;
    assign snk_ready   = ~rst & ((occ_r < DEPTH_L) | pop_s);
    assign accept_s    = snk_valid & snk_ready;
    assign issue_valid = accept_s;
    assign wr_s        = valid_d_r[LATENCY-1];
    assign src_data    = src_valid ? mem_r[rd_ptr_r] : EW'(0);
    assign fifo_level  = level_r;

    // Valid/sideband delay line matching the external pipeline depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_d_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_d_r[i] <= '0;
            end
        end else begin
            valid_d_r[0] <= accept_s;
            data_d_r[0]  <= snk_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_d_r[i] <= valid_d_r[i-1];
                data_d_r[i]  <= data_d_r[i-1];
            end
        end
    end

    // Credit counter: in-flight beats plus FIFO entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r <= '0;
        end else begin
            case ({accept_s, pop_s})
                2'b10:   occ_r <= occ_r + LW'(1);
                2'b01:   occ_r <= occ_r - LW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // FIFO pointers and entry count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({wr_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage; the exit stage merges the pipeline result with its sideband.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= {res_data, data_d_r[LATENCY-1]};
        end
    end

`ifdef BACKPRESSURE_STALL_CNT_EN
    // Saturating count of cycles where a valid beat was refused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (snk_valid && !snk_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    // Stall counting is not built in this configuration.
`endif

endmodule

// File: tb/tb_backpressure_credit_machine.sv
// Scoreboard bench for backpressure_credit_machine with LATENCY=3, FIFO_DEPTH=4.
module tb_backpressure_credit_machine;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snk_valid = 1'b0;
    logic [7:0]  snk_data = 8'h00;
    logic        src_ready = 1'b0;
    logic        snk_ready;
    logic        issue_valid;
    logic [7:0]  res_data;
    logic        src_valid;
    logic [15:0] src_data;
    logic [2:0]  fifo_level;
`ifdef BACKPRESSURE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          model_occ = 0;
    int          pop_count = 0;
    logic [15:0] sb_q [$];

    logic [LAT-1:0] pipe_v = '0;
    logic [7:0]     pipe_d [LAT];
    logic [7:0]     junk = 8'h00;

    backpressure_credit_machine #(
        .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(8), .RES_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_ready(snk_ready),
        .issue_valid(issue_valid), .res_data(res_data),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .fifo_level(fifo_level)
`ifdef BACKPRESSURE_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] res_fn(input logic [7:0] d);
        return d ^ 8'h99;
    endfunction

    // Model of the external fixed-latency pipeline; garbage when no beat exits.
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[LAT-2:0], issue_valid};
        pipe_d[0] <= snk_data;
        for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
        junk <= 8'($urandom);
    end
    assign res_data = pipe_v[LAT-1] ? res_fn(pipe_d[LAT-1]) : junk;

    // Scoreboard and credit model, sampled mid-cycle.
    always @(negedge clk) begin
        logic        exp_ready;
        logic [15:0] exp_data;
        if (rst) begin
            sb_q.delete();
            model_occ = 0;
            checks++;
            if (src_valid !== 1'b0 || fifo_level !== 3'd0 || snk_ready !== 1'b0 || issue_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: src_valid=%b fifo_level=%0d snk_ready=%b issue_valid=%b, required 0/0/0/0",
                         src_valid, fifo_level, snk_ready, issue_valid);
            end
        end else begin
            exp_ready = (model_occ < DEPTH) || (src_valid && src_ready);
            checks++;
            if (snk_ready !== exp_ready) begin
                errors++;
                $display("FAIL snk_ready: got %b, required %b (occ=%0d)", snk_ready, exp_ready, model_occ);
            end
            checks++;
            if (issue_valid !== (snk_valid && exp_ready)) begin
                errors++;
                $display("FAIL issue_valid: got %b, required %b", issue_valid, snk_valid && exp_ready);
            end
            checks++;
            if (!(fifo_level <= 3'd4) || model_occ > DEPTH) begin
                errors++;
                $display("FAIL occupancy_bound: fifo_level=%0d occ=%0d, required <= %0d", fifo_level, model_occ, DEPTH);
            end
            if (snk_valid && snk_ready) begin
                sb_q.push_back({res_fn(snk_data), snk_data});
                model_occ++;
            end
            if (src_valid && src_ready) begin
                pop_count++;
                model_occ--;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h, required no output", src_data);
                end else begin
                    exp_data = sb_q.pop_front();
                    if (src_data !== exp_data) begin
                        errors++;
                        $display("FAIL src_data: got %h, required %h", src_data, exp_data);
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        snk_valid = v;
        snk_data  = d;
        src_ready = r;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        snk_valid = 1'b1;
        src_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (src_valid !== 1'b0 || fifo_level !== 3'd0 || src_data !== 16'h0000 || snk_ready !== 1'b0 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: src_valid=%b level=%0d src_data=%h snk_ready=%b issue=%b, required all zero",
                     src_valid, fifo_level, src_data, snk_ready, issue_valid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        snk_valid = 1'b0;
    endtask

    task automatic test_single();
        repeat (3) step(1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 8; c++) begin
            step(c == 0, 8'hA5, 1'b1);
            checks++;
            if (src_valid !== (c == 4) || issue_valid !== (c == 0)) begin
                errors++;
                $display("FAIL single_timing: cycle %0d src_valid=%b issue_valid=%b, required %b/%b",
                         c, src_valid, issue_valid, c == 4, c == 0);
            end
            if (c == 4) begin
                checks++;
                if (src_data !== 16'h3CA5) begin
                    errors++;
                    $display("FAIL single_data: got %h, required 3ca5", src_data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int pc0 = pop_count;
        int nxt = 4;
        int guard = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 8'(c), 1'b0);
            checks++;
            if (snk_ready !== (c < 4)) begin
                errors++;
                $display("FAIL bp_ready: cycle %0d got %b, required %b", c, snk_ready, c < 4);
            end
            if (c == 7) begin
                checks++;
                if (fifo_level !== 3'd4) begin
                    errors++;
                    $display("FAIL bp_level: got %0d, required 4", fifo_level);
                end
            end
        end
        step(1'b1, 8'(nxt), 1'b1);
`ifdef BACKPRESSURE_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd4) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, required 4", stall_cnt);
        end
`endif
        if (snk_valid && snk_ready) nxt++;
        while (nxt < 8 && guard < 40) begin
            step(1'b1, 8'(nxt), 1'b1);
            if (snk_valid && snk_ready) nxt++;
            guard++;
        end
        repeat (10) step(1'b0, 8'h00, 1'b1);
        checks++;
        if (nxt != 8 || pop_count - pc0 != 8) begin
            errors++;
            $display("FAIL bp_count: accepted to %0d, popped %0d, required 8 and 8", nxt, pop_count - pc0);
        end
    endtask

    task automatic test_throughput();
        int pc0 = pop_count;
        for (int c = 0; c < 30; c++) begin
            step(c < 20, 8'(c + 64), 1'b1);
            checks++;
            if ((c < 20 && snk_ready !== 1'b1) || src_valid !== (c >= 4 && c <= 23) || !(fifo_level <= 3'd1)) begin
                errors++;
                $display("FAIL throughput: cycle %0d snk_ready=%b src_valid=%b level=%0d, required 1/%b/<=1",
                         c, snk_ready, src_valid, fifo_level, c >= 4 && c <= 23);
            end
        end
        checks++;
        if (pop_count - pc0 != 20) begin
            errors++;
            $display("FAIL throughput_count: got %0d, required 20", pop_count - pc0);
        end
    endtask

    task automatic test_random();
        int pc0 = pop_count;
        int sent = 0;
        int cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom_range(0, 1)));
            if (snk_valid && snk_ready) sent++;
            cyc++;
        end
        repeat (20) step(1'b0, 8'h00, 1'b1);
        checks++;
        if (sent != 1000 || pop_count - pc0 != 1000 || sb_q.size() != 0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL random_drain: sent=%0d popped=%0d pending=%0d level=%0d, required 1000/1000/0/0",
                     sent, pop_count - pc0, sb_q.size(), fifo_level);
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checks++;
        if (fifo_level !== 3'd2) begin
            errors++;
            $display("FAIL midflight_level: got %0d, required 2", fifo_level);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        snk_valid = 1'b0;
        #1;
        checks++;
        if (src_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL midflight_async: src_valid=%b level=%0d, required 0/0", src_valid, fifo_level);
        end
`ifdef BACKPRESSURE_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stall_cnt_reset: got %0d, required 0", stall_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (src_valid !== 1'b0 || fifo_level !== 3'd0) begin
                errors++;
                $display("FAIL midflight_stale: cycle %0d src_valid=%b level=%0d, required 0/0", c, src_valid, fifo_level);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_throughput();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
